// File: rtl/wb_reg_bank_pkg.sv
// wb_reg_bank_pkg: shared constants, register mode enum and byte-lane merge helper.
package wb_reg_bank_pkg;

    localparam int WB_DW = 32;

    typedef enum logic {REG_RW, REG_RO} t_reg_mode;

    function automatic logic [WB_DW-1:0] merge_be(input logic [WB_DW-1:0] old_v,
                                                  input logic [WB_DW-1:0] new_v,
                                                  input logic [3:0] sel);
        logic [WB_DW-1:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = sel[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        return r;
    endfunction

endpackage

// File: rtl/wb_reg_cell.sv
// wb_reg_cell: one bank register; byte-masked write and strobe for RW, constant zero for RO.
module wb_reg_cell
    import wb_reg_bank_pkg::*;
#(
    parameter logic [WB_DW-1:0] RST_VAL = '0,
    parameter t_reg_mode MODE = REG_RW
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en,
    input  logic [WB_DW-1:0] wr_dat,
    input  logic [3:0]       wr_sel,
    output logic [WB_DW-1:0] value,
    output logic             strobe
);
    localparam bit RW = (MODE == REG_RW);

    logic [WB_DW-1:0] q;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) q <= RST_VAL;
        else if (wr_en && RW) q <= merge_be(q, wr_dat, wr_sel);

    // RO slots keep no state; the bank reads their fabric source directly
    assign value  = RW ? q : '0;
    assign strobe = wr_en && RW;

endmodule

// File: rtl/wb_reg_bank.sv
// wb_reg_bank: pipelined Wishbone slave exposing NREGS word registers (RW or RO per slot).
module wb_reg_bank
    import wb_reg_bank_pkg::*;
#(
    parameter int NREGS = 4,
    parameter logic [NREGS-1:0] RO_MASK = '0,
    parameter logic [NREGS*WB_DW-1:0] RST_VAL = '0,
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    input  logic [AW+2:2]          wb_adr_i,
    input  logic [3:0]             wb_sel_i,
    input  logic                   wb_we_i,
    input  logic [WB_DW-1:0]       wb_dat_i,
    output logic                   wb_ack_o,
    output logic                   wb_err_o,
    output logic                   wb_rty_o,
    output logic                   wb_stall_o,
    output logic [WB_DW-1:0]       wb_dat_o,
    output logic [NREGS*WB_DW-1:0] regs_o,
    input  logic [NREGS*WB_DW-1:0] regs_i,
    output logic [NREGS-1:0]       wr_strobe_o
);
    logic             en, rd_req, wr_req, rd_map, wr_map;
    logic             rd_ack, rd_err, wr_v;
    logic [AW:0]      wr_adr;
    logic [WB_DW-1:0] wr_dat, rd_mux;
    logic [3:0]       wr_sel;
    logic [WB_DW-1:0] vals [NREGS];

    // the in-progress flags are exactly the done-cycle flags since latency is fixed at one
    assign en     = wb_cyc_i & wb_stb_i;
    assign rd_req = en & ~wb_we_i & ~(rd_ack | rd_err);
    assign wr_req = en & wb_we_i & ~wr_v;
    assign rd_map = 32'(wb_adr_i) < NREGS;
    assign wr_map = 32'(wr_adr) < NREGS;

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NREGS; i++)
            if (32'(wb_adr_i) == 32'(i)) rd_mux = RO_MASK[i] ? regs_i[i*WB_DW +: WB_DW] : vals[i];
    end

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            rd_ack   <= 1'b0;
            rd_err   <= 1'b0;
            wr_v     <= 1'b0;
            wr_adr   <= '0;
            wr_dat   <= '0;
            wr_sel   <= '0;
            wb_dat_o <= '0;
        end else begin
            rd_ack <= rd_req & rd_map;
            rd_err <= rd_req & ~rd_map;
            wr_v   <= wr_req;
            if (rd_req) wb_dat_o <= rd_mux;
            if (wr_req) begin
                wr_adr <= wb_adr_i;
                wr_dat <= wb_dat_i;
                wr_sel <= wb_sel_i;
            end
        end

    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        wb_reg_cell #(
            .RST_VAL(RST_VAL[i*WB_DW +: WB_DW]),
            .MODE   (RO_MASK[i] ? REG_RO : REG_RW)
        ) u_cell (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .wr_en (wr_v && 32'(wr_adr) == 32'(i)),
            .wr_dat(wr_dat),
            .wr_sel(wr_sel),
            .value (vals[i]),
            .strobe(wr_strobe_o[i])
        );
        assign regs_o[i*WB_DW +: WB_DW] = vals[i];
    end

    assign wb_ack_o   = rd_ack | (wr_v & wr_map);
    assign wb_err_o   = rd_err | (wr_v & ~wr_map);
    assign wb_rty_o   = 1'b0;
    assign wb_stall_o = ~(wb_ack_o | wb_err_o) & en;

endmodule
